// File: rtl/cache_valid_array.sv
// cache_valid_array
//   Valid-bit store for the L1 data cache: one NUM_WAY-bit valid vector per
//   set, indexed by the same set index as the tag array. Supports masked
//   writes, a registered read with a first-invalid-way hint, and an
//   invalidate-all sweep. The sweep runs automatically after reset.
//
// Ports
//   clk          clock, all state changes on the rising edge
//   rst          synchronous active-high reset
//   mem_en       access enable
//   rd_wr        0 = read, 1 = write
//   addr         access address, set index = addr[SET_BITS-1:0]
//   wr_mask      per-way write enable
//   data_in      per-way write data
//   data_out     registered read vector
//   first_inv    lowest invalid way of the last read vector (0 if none)
//   all_valid    every way of the last read vector is valid
//   inv_all_req  single-cycle request to clear all valid bits
//   inv_busy     sweep in progress, accesses ignored
//   inv_done     one-cycle pulse on the final sweep cycle
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | accesses accepted, inv_all_req starts a sweep
// SWEEP  | one set cleared per cycle, accesses and requests ignored

module cache_valid_array #(
  parameter int NUM_WAY  = 8,
  parameter int NUM_SET  = 128,
  parameter int SET_BITS = $clog2(NUM_SET),
  parameter int WAY_BITS = (NUM_WAY > 1) ? $clog2(NUM_WAY) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                mem_en,
  input  logic                rd_wr,
  input  logic [31:0]         addr,
  input  logic [NUM_WAY-1:0]  wr_mask,
  input  logic [NUM_WAY-1:0]  data_in,
  output logic [NUM_WAY-1:0]  data_out,
  output logic [WAY_BITS-1:0] first_inv,
  output logic                all_valid,
  input  logic                inv_all_req,
  output logic                inv_busy,
  output logic                inv_done
);

  typedef enum logic {ST_IDLE, ST_SWEEP} state_t;

  state_t              state;
  logic [SET_BITS-1:0] sweep_cnt;
  logic [SET_BITS-1:0] idx;
  logic [NUM_WAY-1:0]  mem [NUM_SET];
  logic [NUM_WAY-1:0]  rd_vec;
  logic [WAY_BITS-1:0] rd_first_inv;
  logic                access;
  logic                do_read;
  logic                do_write;
  logic                last_clear;
  logic                pre_last_clear;
  logic                unused_addr;

  assign idx         = addr[SET_BITS-1:0];
  assign unused_addr = ^addr[31:SET_BITS];
  assign rd_vec      = mem[idx];

  // An invalidate request in IDLE takes priority and drops a same-cycle access.
  assign access   = (state == ST_IDLE) && mem_en && !inv_all_req;
  assign do_read  = access && !rd_wr;
  assign do_write = access && rd_wr;

  assign last_clear     = (sweep_cnt == SET_BITS'(NUM_SET - 1));
  assign pre_last_clear = (sweep_cnt == SET_BITS'(NUM_SET - 2));

  always_comb begin
    rd_first_inv = '0;
    for (int i = NUM_WAY - 1; i >= 0; i--) begin
      if (!rd_vec[i]) rd_first_inv = WAY_BITS'(i);
    end
  end

  // Storage is deliberately not reset; the post-reset sweep initialises it.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == ST_SWEEP) begin
        mem[sweep_cnt] <= '0;
      end else if (do_write) begin
        mem[idx] <= (rd_vec & ~wr_mask) | (data_in & wr_mask);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_SWEEP;
      sweep_cnt <= '0;
      inv_busy  <= 1'b1;
      inv_done  <= 1'b0;
      data_out  <= '0;
      first_inv <= '0;
      all_valid <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          inv_done <= 1'b0;
          if (inv_all_req) begin
            state     <= ST_SWEEP;
            sweep_cnt <= '0;
            inv_busy  <= 1'b1;
          end else if (do_read) begin
            data_out  <= rd_vec;
            first_inv <= rd_first_inv;
            all_valid <= &rd_vec;
          end
        end
        ST_SWEEP: begin
          // inv_done is registered one cycle early so it is high during the
          // cycle in which the last set is cleared.
          inv_done <= pre_last_clear;
          if (last_clear) begin
            state    <= ST_IDLE;
            inv_busy <= 1'b0;
          end else begin
            sweep_cnt <= sweep_cnt + SET_BITS'(1);
          end
        end
        default: begin
          state     <= ST_SWEEP;
          sweep_cnt <= '0;
          inv_busy  <= 1'b1;
          inv_done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/cache_valid_array.md
Name: cache_valid_array

Overview:
- Parametrised valid-bit store for the L1 data cache: one NUM_WAY-bit valid vector per set.
- Adds the following over the fixed 8x128 valid memory:
  - per-way write mask (read-modify-write);
  - a sequential invalidate-all sweep with a busy/done handshake, started automatically after reset;
  - a registered first-invalid-way hint for the replacement logic.
- Sits beside the tag array in the cache controller and is addressed by the same set index.

Parameters:
- NUM_WAY, 8, number of ways (valid bits per set), 1..32
- NUM_SET, 128, number of sets, power of two, >= 2
- SET_BITS, $clog2(NUM_SET), set index width (derived)
- WAY_BITS, $clog2(NUM_WAY) (min 1), width of the way index (derived)

Ports:
- clk  in  1  clock; all state changes on the rising edge
- rst  in  1  synchronous active-high reset
- mem_en  in  1  access enable; 1 = access this cycle
- rd_wr  in  1  0 = read, 1 = write
- addr  in  32  access address; set index = addr[SET_BITS-1:0], upper bits ignored
- wr_mask  in  NUM_WAY  per-way write enable for writes
- data_in  in  NUM_WAY  write data, per way
- data_out  out  NUM_WAY  registered read data
- first_inv  out  WAY_BITS  lowest-numbered invalid way in the last read vector
- all_valid  out  1  1 = every bit of the last read vector is set
- inv_all_req  in  1  single-cycle request to clear every valid bit
- inv_busy  out  1  1 = sweep in progress; accesses are ignored
- inv_done  out  1  one-cycle pulse on the final sweep cycle

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- Storage: NUM_SET x NUM_WAY flop array. Contents are undefined until the first sweep completes.
- Reset (rst=1 at an edge):
  - data_out=0, first_inv=0, all_valid=0, inv_done=0;
  - inv_busy=1, sweep counter=0, state=SWEEP.
  - A sweep therefore always runs after reset deassertion. Reset asserted mid-sweep restarts the counter at 0.
- States:
  - IDLE: accesses accepted.
  - SWEEP: one set per cycle is cleared (set[cnt] <= 0, cnt <= cnt+1).
  - On the cycle cnt == NUM_SET-1: clear the set, assert inv_done for that cycle, go to IDLE.
  - inv_busy drops on the following cycle.
  - Sweep length is exactly NUM_SET cycles.
- IDLE -> SWEEP: inv_all_req=1 in IDLE. The first clear happens on the next cycle.
  - If mem_en=1 in the same cycle, inv_all_req wins and the access is dropped: no write, data_out holds.
- inv_all_req during SWEEP is ignored; the sweep does not restart. mem_en during SWEEP is ignored.
- Read (IDLE, mem_en=1, rd_wr=0):
  - 1-cycle latency: data_out <= set[idx].
  - first_inv <= index of the lowest 0 bit of that vector, or 0 if none.
  - all_valid <= &set[idx].
- Write (IDLE, mem_en=1, rd_wr=1):
  - set[idx] <= (set[idx] & ~wr_mask) | (data_in & wr_mask), completed in one cycle.
  - wr_mask = 0 leaves the set unchanged.
  - data_out, first_inv and all_valid hold.
- data_out, first_inv and all_valid hold whenever no read completes, including all of SWEEP. The exception is reset, which clears them.
- Single port: a read and a write are never in the same cycle. A read on the cycle after a write to the same set returns the updated value.
- Address bits above SET_BITS never alias into storage state.

Test Plan:
- Reset then release: inv_busy=1 for exactly 128 cycles, inv_done pulses on cycle 128, then a read of set 5 gives data_out=8'h00, first_inv=0, all_valid=0.
- Write set 3, wr_mask=8'hFF, data_in=8'hA5, then write set 3, wr_mask=8'h0F, data_in=8'h00, then read set 3 -> data_out=8'hA0, first_inv=0, all_valid=0.
- Write set 127 = 8'hFF (full mask), then read -> all_valid=1, first_inv=0. Then write mask 8'h10, data 8'h00, then read -> data_out=8'hEF, first_inv=4.
- Load several sets, pulse inv_all_req together with a write to set 7 of 8'hFF: the write is dropped, busy is high for 128 cycles, and reads afterwards return 0.
- Issue mem_en reads/writes and a second inv_all_req mid-sweep: no storage change beyond the clears, data_out holds, the sweep ends at the original cycle-128 point.
- Assert rst at sweep count 60: the counter restarts, giving a full 128-cycle sweep after release. Read at addr=32'hFFFF_FF83 accesses set 3 (NUM_SET=128). Repeat with NUM_WAY=4, NUM_SET=16 for parametrisation.
